// File: rtl/fetch_pkg.sv
// +------------------------------------------------------------------+
// | Module   : fetch_pkg                                              |
// | Brief    : Shared constants and types for the RV32I fetch stage.  |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
   localparam int          DEFAULT_FIFO_DEPTH = 2;
   localparam logic [31:0] INST_NOP           = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +------------------------------------------------------------------+
// | Module   : fetch_fifo                                             |
// | Brief    : Synchronous FIFO of fetch entries; flush beats push.   |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  fetch_entry_t                 din,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t    r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_do_push;
   logic            w_do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign w_do_pop  = pop && (r_count != '0);
   assign w_do_push = push && ((r_count < CW'(DEPTH)) || w_do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// +------------------------------------------------------------------+
// | Module   : instruction_fetch_unit                                 |
// | Brief    : RV32I IF stage: PC, 1-cycle imem request, output FIFO. |
// |            Optional misaligned-redirect trap: FETCH_MISALIGN_CHECK_EN |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_pc,
   output logic [29:0]  ic_addr,
   input  logic [31:0]  ic_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_pc,
   output logic [31:0]  out_inst,
   output logic         fetch_err
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = CW + 1;

   logic [31:0]   r_pc;
   logic [31:0]   r_req_pc;
   logic          r_inflight;
   logic          r_fetch_err;

   logic [CW-1:0] w_count;
   logic [OW-1:0] w_occ;
   logic          w_pop;
   logic          w_push;
   logic          w_issue;
   logic          w_misalign;
   logic          w_hold;
   logic [31:0]   w_target;
   fetch_entry_t  w_din;
   fetch_entry_t  w_head;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign w_hold     = r_fetch_err;
`else
   logic  w_unused_lsbs;
   assign w_unused_lsbs = ^redirect_pc[1:0];
   assign w_misalign    = 1'b0;
   assign w_hold        = 1'b0;
`endif

   assign w_target = {redirect_pc[31:2], 2'b00};
   assign ic_addr  = redirect_valid ? redirect_pc[31:2] : r_pc[31:2];

   assign w_pop   = out_valid && out_ready;
   // Occupancy the FIFO will have after this cycle's push/pop; a new issue lands one cycle later.
   assign w_occ   = {1'b0, w_count} + OW'(r_inflight) - OW'(w_pop);
   assign w_issue = !redirect_valid && !w_hold && (w_occ < OW'(FIFO_DEPTH));

   // A word returning in a redirect cycle belongs to the wrong path.
   assign w_push    = r_inflight && !redirect_valid;
   assign w_din.pc   = r_req_pc;
   assign w_din.inst = ic_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RESET_PC;
         r_req_pc    <= '0;
         r_inflight  <= 1'b0;
         r_fetch_err <= 1'b0;
      end else if (redirect_valid) begin
         r_fetch_err <= w_misalign;
         if (w_misalign) begin
            r_inflight <= 1'b0;
         end else begin
            r_inflight <= 1'b1;
            r_req_pc   <= w_target;
            r_pc       <= w_target + 32'd4;
         end
      end else if (w_issue) begin
         r_inflight <= 1'b1;
         r_req_pc   <= r_pc;
         r_pc       <= r_pc + 32'd4;
      end else begin
         r_inflight <= 1'b0;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .flush (redirect_valid),
      .din   (w_din),
      .head  (w_head),
      .count (w_count)
   );

   assign out_valid = (w_count != '0);
   assign out_pc    = w_head.pc;
   assign out_inst  = w_head.inst;
   assign fetch_err = r_fetch_err;

endmodule

`default_nettype wire
